// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/sub/negate/pass sequencer: one full adder is stepped LSB-first
// over WIDTH cycles and produces a result plus carry and signed-overflow flags.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_sh, y_sh, work;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum, fa_cout;
    logic [WIDTH-1:0] prep_x, prep_y;
    logic             prep_cin;
    logic             last_bit;

    full_adder u_fa (
        .a    (x_sh[0]),
        .b    (y_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Subtract and negate are a + ~b + 1 and ~a + 0 + 1 on the same adder.
    always_comb begin
        prep_x   = a;
        prep_y   = '0;
        prep_cin = 1'b0;
        case (op)
            2'b00: prep_y = b;
            2'b01: begin prep_y = ~b; prep_cin = 1'b1; end
            2'b10: begin prep_x = ~a; prep_cin = 1'b1; end
            default: ;
        endcase
    end

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            x_sh      <= '0;
            y_sh      <= '0;
            work      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x_sh  <= prep_x;
                        y_sh  <= prep_y;
                        carry <= prep_cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work  <= {fa_sum, work[WIDTH-1:1]};
                    x_sh  <= x_sh >> 1;
                    y_sh  <= y_sh >> 1;
                    carry <= fa_cout;
                    if (last_bit) begin
                        // carry still holds Cin of the MSB here, so overflow is Cin^Cout.
                        result    <= {fa_sum, work[WIDTH-1:1]};
                        carry_out <= fa_cout;
                        overflow  <= carry ^ fa_cout;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
